// File: rtl/lsq_if.sv
// Purpose: issue/AGU/CDB/commit/load-result/data-memory bundle for the load/store queue.
// Ports: master = issue stage, AGU, CDB, ROB, load consumer and data memory side;
//        slave  = the load/store queue itself.
interface lsq_if #(
  parameter int unsigned N_LD   = 4,
  parameter int unsigned N_ST   = 8,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned IDX_W = $clog2(N_LD > N_ST ? N_LD : N_ST);

  logic              alloc_valid;
  logic              alloc_is_st;
  logic [TAG_W-1:0]  alloc_tag;
  logic              alloc_dvalid;
  logic [DATA_W-1:0] alloc_data;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_idx;
  logic              agu_valid;
  logic              agu_is_st;
  logic [IDX_W-1:0]  agu_idx;
  logic [ADDR_W-1:0] agu_addr;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              commit_valid;
  logic              commit_ready;
  logic              ld_valid;
  logic              ld_ready;
  logic [TAG_W-1:0]  ld_tag;
  logic [DATA_W-1:0] ld_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output alloc_valid, alloc_is_st, alloc_tag, alloc_dvalid, alloc_data,
    input  alloc_ready, alloc_idx,
    output agu_valid, agu_is_st, agu_idx, agu_addr,
    output cdb_valid, cdb_tag, cdb_data,
    output commit_valid,
    input  commit_ready,
    input  ld_valid, ld_tag, ld_data,
    output ld_ready,
    input  mem_we, mem_waddr, mem_wdata, mem_raddr,
    output mem_rdata
  );

  modport slave (
    input  alloc_valid, alloc_is_st, alloc_tag, alloc_dvalid, alloc_data,
    output alloc_ready, alloc_idx,
    input  agu_valid, agu_is_st, agu_idx, agu_addr,
    input  cdb_valid, cdb_tag, cdb_data,
    input  commit_valid,
    output commit_ready,
    output ld_valid, ld_tag, ld_data,
    input  ld_ready,
    output mem_we, mem_waddr, mem_wdata, mem_raddr,
    input  mem_rdata
  );
endinterface

// File: rtl/lsq_param.sv
// Purpose: parametrised in-order load/store queue with store-to-load forwarding,
//          CDB snooping for store data and memory write at ROB store commit.
// Ports: clk, reset (async, active-high); io (lsq_if.slave) carries allocation,
//        AGU address write, CDB, commit handshake, load result and data memory.
module lsq_param #(
  parameter int unsigned N_LD   = 4,
  parameter int unsigned N_ST   = 8,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32
) (
  input logic  clk,
  input logic  reset,
  lsq_if.slave io
);
  localparam int unsigned LD_IW = $clog2(N_LD);
  localparam int unsigned ST_IW = $clog2(N_ST);
  localparam int unsigned LW    = LD_IW + 1;
  localparam int unsigned PW    = ST_IW + 1;
  localparam int unsigned IDX_W = $clog2(N_LD > N_ST ? N_LD : N_ST);

  typedef struct packed {
    logic              busy;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic [PW-1:0]     snap;
  } ld_entry_t;

  typedef struct packed {
    logic              busy;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic [DATA_W-1:0] data;
    logic              dvalid;
  } st_entry_t;

  ld_entry_t         ldq [N_LD];
  st_entry_t         stq [N_ST];
  logic [LW-1:0]     ld_head, ld_tail;
  logic [PW-1:0]     st_head, st_tail;
  logic              js_valid;
  logic [ADDR_W-1:0] js_addr;
  logic [DATA_W-1:0] js_data;
  logic              res_valid, res_fresh;
  logic [TAG_W-1:0]  res_tag;
  logic [ADDR_W-1:0] res_addr;
  logic [PW-1:0]     res_snap;
  logic [DATA_W-1:0] res_hold;

  logic              ld_empty, ld_full, st_empty, st_full;
  logic [LD_IW-1:0]  ld_hi, agu_ld_idx;
  logic [ST_IW-1:0]  st_hi, agu_st_idx;
  ld_entry_t         ld_h;
  st_entry_t         st_h;
  logic              older_ok, ld_issue, st_commit, commit_ok, alloc_ok, alloc_fire, agu_live;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data, resolved;
  logic [PW-1:0]     ld_dist, res_dist;
  logic [ST_IW-1:0]  os, rs;

  // Stores older than a load; zero once the store head has reached or passed its snapshot.
  function automatic logic [PW-1:0] older_cnt(input logic [PW-1:0] snap, input logic [PW-1:0] head);
    logic [PW-1:0] d;
    d = snap - head;
    return (d > PW'(N_ST)) ? '0 : d;
  endfunction

  assign ld_hi      = ld_head[LD_IW-1:0];
  assign st_hi      = st_head[ST_IW-1:0];
  assign ld_h       = ldq[ld_hi];
  assign st_h       = stq[st_hi];
  assign ld_empty   = (ld_head == ld_tail);
  assign st_empty   = (st_head == st_tail);
  assign ld_full    = (ld_hi == ld_tail[LD_IW-1:0]) && (ld_head[LD_IW] != ld_tail[LD_IW]);
  assign st_full    = (st_hi == st_tail[ST_IW-1:0]) && (st_head[ST_IW] != st_tail[ST_IW]);
  assign agu_ld_idx = LD_IW'(io.agu_idx);
  assign agu_st_idx = ST_IW'(io.agu_idx);
  assign agu_live   = io.agu_is_st ? stq[agu_st_idx].busy : ldq[agu_ld_idx].busy;

  // Head load may issue only when every older store has both address and data.
  always_comb begin
    older_ok = 1'b1;
    os       = '0;
    ld_dist  = older_cnt(ld_h.snap, st_head);
    for (int k = 0; k < N_ST; k++) begin
      os = st_hi + ST_IW'(k);
      if ((PW'(k) < ld_dist) && !(stq[os].addr_valid && stq[os].dvalid)) older_ok = 1'b0;
    end
  end

  assign commit_ok  = !st_empty && st_h.addr_valid && st_h.dvalid;
  assign st_commit  = io.commit_valid && commit_ok;
  assign ld_issue   = !ld_empty && ld_h.addr_valid && older_ok && (!res_valid || io.ld_ready);
  // A pop in the same cycle frees the slot the push needs.
  assign alloc_ok   = io.alloc_is_st ? (!st_full || st_commit) : (!ld_full || ld_issue);
  assign alloc_fire = io.alloc_valid && alloc_ok;

  // Result data for the load issued last cycle: youngest still-queued older store,
  // then the store committed last cycle, then memory.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    rs       = '0;
    res_dist = older_cnt(res_snap, st_head);
    for (int k = 0; k < N_ST; k++) begin
      rs = st_hi + ST_IW'(k);
      if ((PW'(k) < res_dist) && stq[rs].addr_valid && (stq[rs].addr == res_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = stq[rs].data;
      end
    end
    if (fwd_hit)                            resolved = fwd_data;
    else if (js_valid && js_addr == res_addr) resolved = js_data;
    else                                    resolved = io.mem_rdata;
  end

  assign io.alloc_ready  = alloc_ok;
  assign io.alloc_idx    = io.alloc_is_st ? IDX_W'(st_tail[ST_IW-1:0]) : IDX_W'(ld_tail[LD_IW-1:0]);
  assign io.commit_ready = commit_ok;
  assign io.mem_we       = st_commit;
  assign io.mem_waddr    = st_h.addr;
  assign io.mem_wdata    = st_h.data;
  assign io.mem_raddr    = ld_h.addr;
  assign io.ld_valid     = res_valid;
  assign io.ld_tag       = res_tag;
  assign io.ld_data      = res_fresh ? resolved : res_hold;

  // Queue state, just_stored and load result stage; later writes to a slot win.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_head <= '0;
      ld_tail <= '0;
      st_head <= '0;
      st_tail <= '0;
      for (int i = 0; i < N_LD; i++) ldq[i] <= '0;
      for (int i = 0; i < N_ST; i++) stq[i] <= '0;
      js_valid  <= 1'b0;
      js_addr   <= '0;
      js_data   <= '0;
      res_valid <= 1'b0;
      res_fresh <= 1'b0;
      res_tag   <= '0;
      res_addr  <= '0;
      res_snap  <= '0;
      res_hold  <= '0;
    end else begin
      if (io.agu_valid && agu_live) begin
        if (io.agu_is_st) begin
          stq[agu_st_idx].addr       <= io.agu_addr;
          stq[agu_st_idx].addr_valid <= 1'b1;
        end else begin
          ldq[agu_ld_idx].addr       <= io.agu_addr;
          ldq[agu_ld_idx].addr_valid <= 1'b1;
        end
      end
      for (int i = 0; i < N_ST; i++) begin
        if (io.cdb_valid && stq[i].busy && !stq[i].dvalid && stq[i].tag == io.cdb_tag) begin
          stq[i].data   <= io.cdb_data;
          stq[i].dvalid <= 1'b1;
        end
      end
      if (st_commit) begin
        stq[st_hi] <= '0;
        st_head    <= st_head + PW'(1);
      end
      js_valid <= st_commit;
      js_addr  <= st_h.addr;
      js_data  <= st_h.data;
      if (ld_issue) begin
        ldq[ld_hi] <= '0;
        ld_head    <= ld_head + LW'(1);
      end
      if (alloc_fire) begin
        if (io.alloc_is_st) begin
          stq[st_tail[ST_IW-1:0]] <= '{busy: 1'b1, tag: io.alloc_tag, addr: '0, addr_valid: 1'b0,
                                       data: io.alloc_dvalid ? io.alloc_data : io.cdb_data,
                                       dvalid: io.alloc_dvalid ||
                                               (io.cdb_valid && io.cdb_tag == io.alloc_tag)};
          st_tail <= st_tail + PW'(1);
        end else begin
          ldq[ld_tail[LD_IW-1:0]] <= '{busy: 1'b1, tag: io.alloc_tag, addr: '0, addr_valid: 1'b0,
                                       snap: st_tail};
          ld_tail <= ld_tail + LW'(1);
        end
      end
      if (ld_issue) begin
        res_valid <= 1'b1;
        res_tag   <= ld_h.tag;
        res_addr  <= ld_h.addr;
        res_snap  <= ld_h.snap;
      end else if (io.ld_ready) begin
        res_valid <= 1'b0;
      end
      res_fresh <= ld_issue;
      // Freeze the result on its first cycle so it stays stable while the consumer stalls.
      if (res_fresh) res_hold <= resolved;
    end
  end

  agu_to_live_slot: assert property (@(posedge clk) disable iff (reset) io.agu_valid |-> agu_live);

endmodule

// File: tb/tb_lsq_param.sv
// Purpose: directed self-checking bench for lsq_param with a 1-cycle synchronous-read memory model.
// Ports: none; drives the lsq_if bundle, clk and reset.
module tb_lsq_param;
  localparam int unsigned N_LD   = 4;
  localparam int unsigned N_ST   = 8;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DATA_W = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   st_t;
  int   ld_t;
  logic [DATA_W-1:0] mem [256];

  lsq_if #(.N_LD(N_LD), .N_ST(N_ST), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  lsq_param #(.N_LD(N_LD), .N_ST(N_ST), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: preset pattern A000_0000|addr, write on mem_we, read data one cycle later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_we) mem[bus.mem_waddr[7:0]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_raddr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid  = 1'b0;
    bus.alloc_is_st  = 1'b0;
    bus.alloc_tag    = '0;
    bus.alloc_dvalid = 1'b0;
    bus.alloc_data   = '0;
    bus.agu_valid    = 1'b0;
    bus.agu_is_st    = 1'b0;
    bus.agu_idx      = '0;
    bus.agu_addr     = '0;
    bus.cdb_valid    = 1'b0;
    bus.cdb_tag      = '0;
    bus.cdb_data     = '0;
    bus.commit_valid = 1'b0;
    bus.ld_ready     = 1'b1;
  endtask

  task automatic push_st(input logic [TAG_W-1:0] tag, input logic dv, input logic [DATA_W-1:0] data);
    bus.alloc_valid  = 1'b1;
    bus.alloc_is_st  = 1'b1;
    bus.alloc_tag    = tag;
    bus.alloc_dvalid = dv;
    bus.alloc_data   = data;
    #1;
    check("st_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    check("st_alloc_idx", 64'(bus.alloc_idx), 64'(st_t));
    tick();
    bus.alloc_valid  = 1'b0;
    bus.alloc_dvalid = 1'b0;
    st_t = (st_t + 1) % N_ST;
  endtask

  task automatic push_ld(input logic [TAG_W-1:0] tag);
    bus.alloc_valid = 1'b1;
    bus.alloc_is_st = 1'b0;
    bus.alloc_tag   = tag;
    #1;
    check("ld_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    check("ld_alloc_idx", 64'(bus.alloc_idx), 64'(ld_t));
    tick();
    bus.alloc_valid = 1'b0;
    ld_t = (ld_t + 1) % N_LD;
  endtask

  task automatic agu(input logic is_st, input int idx, input logic [ADDR_W-1:0] addr);
    bus.agu_valid = 1'b1;
    bus.agu_is_st = is_st;
    bus.agu_idx   = 3'(idx);
    bus.agu_addr  = addr;
    tick();
    bus.agu_valid = 1'b0;
  endtask

  task automatic commit_one(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    bus.commit_valid = 1'b1;
    #1;
    check("commit_ready", 64'(bus.commit_ready), 64'd1);
    check("mem_we_on", 64'(bus.mem_we), 64'd1);
    check("mem_waddr", 64'(bus.mem_waddr), 64'(addr));
    check("mem_wdata", 64'(bus.mem_wdata), 64'(data));
    tick();
    bus.commit_valid = 1'b0;
    #1;
    check("mem_we_off", 64'(bus.mem_we), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    st_t     = 0;
    ld_t     = 0;
    idle();
    reset = 1'b1;
    tick();
    check("rst_ld_valid", 64'(bus.ld_valid), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_commit_ready", 64'(bus.commit_ready), 64'd0);
    check("rst_alloc_ready_ld", 64'(bus.alloc_ready), 64'd1);
    tick();
    reset = 1'b0;
    tick();

    // 1: forward from a queued store
    push_st(6'd1, 1'b1, 32'd5);
    agu(1'b1, 0, 17'h10);
    push_ld(6'd10);
    #1;
    check("t1_no_addr", 64'(bus.ld_valid), 64'd0);
    agu(1'b0, 0, 17'h10);
    check("t1_issue_cycle", 64'(bus.ld_valid), 64'd0);
    check("t1_mem_raddr", 64'(bus.mem_raddr), 64'h10);
    tick();
    check("t1_valid", 64'(bus.ld_valid), 64'd1);
    check("t1_tag", 64'(bus.ld_tag), 64'd10);
    check("t1_data", 64'(bus.ld_data), 64'd5);
    tick();
    check("t1_consumed", 64'(bus.ld_valid), 64'd0);

    // 2: two older stores to one address, second gets data from the CDB; youngest wins
    push_st(6'd2, 1'b1, 32'd1);
    push_st(6'd3, 1'b0, 32'd0);
    agu(1'b1, 1, 17'h20);
    agu(1'b1, 2, 17'h20);
    push_ld(6'd11);
    agu(1'b0, 1, 17'h20);
    check("t2_wait_data", 64'(bus.ld_valid), 64'd0);
    tick();
    check("t2_wait_data2", 64'(bus.ld_valid), 64'd0);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = 6'd3;
    bus.cdb_data  = 32'd2;
    tick();
    bus.cdb_valid = 1'b0;
    check("t2_issue_cycle", 64'(bus.ld_valid), 64'd0);
    tick();
    check("t2_valid", 64'(bus.ld_valid), 64'd1);
    check("t2_tag", 64'(bus.ld_tag), 64'd11);
    check("t2_data", 64'(bus.ld_data), 64'd2);
    tick();

    // 3: load waits for an older store address, then reads memory
    push_st(6'd4, 1'b1, 32'd7);
    push_ld(6'd12);
    agu(1'b0, 2, 17'h40);
    check("t3_blocked0", 64'(bus.ld_valid), 64'd0);
    tick();
    check("t3_blocked1", 64'(bus.ld_valid), 64'd0);
    tick();
    check("t3_blocked2", 64'(bus.ld_valid), 64'd0);
    agu(1'b1, 3, 17'h44);
    check("t3_issue_cycle", 64'(bus.ld_valid), 64'd0);
    tick();
    check("t3_valid", 64'(bus.ld_valid), 64'd1);
    check("t3_tag", 64'(bus.ld_tag), 64'd12);
    check("t3_data_mem", 64'(bus.ld_data), 64'hA000_0040);
    tick();

    // 4: drain stores, then commit and issue the same cycle (just_stored path)
    commit_one(17'h10, 32'd5);
    commit_one(17'h20, 32'd1);
    commit_one(17'h20, 32'd2);
    commit_one(17'h44, 32'd7);
    push_st(6'd5, 1'b1, 32'd9);
    agu(1'b1, 4, 17'h30);
    push_ld(6'd13);
    agu(1'b0, 3, 17'h30);
    bus.commit_valid = 1'b1;
    #1;
    check("t4_commit_ready", 64'(bus.commit_ready), 64'd1);
    check("t4_mem_we", 64'(bus.mem_we), 64'd1);
    check("t4_waddr", 64'(bus.mem_waddr), 64'h30);
    check("t4_wdata", 64'(bus.mem_wdata), 64'd9);
    tick();
    bus.commit_valid = 1'b0;
    #1;
    check("t4_we_once", 64'(bus.mem_we), 64'd0);
    check("t4_valid", 64'(bus.ld_valid), 64'd1);
    check("t4_tag", 64'(bus.ld_tag), 64'd13);
    check("t4_data_js", 64'(bus.ld_data), 64'd9);
    tick();

    // 5: fill the store queue, then commit and allocate in one cycle across the wrap
    for (int k = 0; k < N_ST; k++) push_st(6'(20 + k), 1'b1, 32'h100 + 32'(k));
    agu(1'b1, 5, 17'h50);
    bus.alloc_valid  = 1'b1;
    bus.alloc_is_st  = 1'b1;
    bus.alloc_tag    = 6'd40;
    bus.alloc_dvalid = 1'b1;
    bus.alloc_data   = 32'h1FF;
    #1;
    check("t5_full", 64'(bus.alloc_ready), 64'd0);
    bus.commit_valid = 1'b1;
    #1;
    check("t5_ready_on_pop", 64'(bus.alloc_ready), 64'd1);
    check("t5_idx", 64'(bus.alloc_idx), 64'd5);
    check("t5_commit_ready", 64'(bus.commit_ready), 64'd1);
    check("t5_waddr", 64'(bus.mem_waddr), 64'h50);
    check("t5_wdata", 64'(bus.mem_wdata), 64'h100);
    tick();
    bus.commit_valid = 1'b0;
    bus.alloc_dvalid = 1'b0;
    #1;
    check("t5_still_full", 64'(bus.alloc_ready), 64'd0);
    check("t5_head_no_addr", 64'(bus.commit_ready), 64'd0);
    bus.alloc_is_st = 1'b0;
    #1;
    check("t5_ld_ready", 64'(bus.alloc_ready), 64'd1);
    bus.alloc_valid = 1'b0;

    reset = 1'b1;
    #1;
    bus.alloc_is_st = 1'b1;
    #1;
    check("rst2_alloc_ready_st", 64'(bus.alloc_ready), 64'd1);
    check("rst2_commit_ready", 64'(bus.commit_ready), 64'd0);
    tick();
    reset = 1'b0;
    st_t = 0;
    ld_t = 0;
    tick();

    // 6: stalled consumer holds the result; reset drops it at once
    push_ld(6'd20);
    bus.ld_ready = 1'b0;
    agu(1'b0, 0, 17'h60);
    push_ld(6'd21);
    check("t6_valid", 64'(bus.ld_valid), 64'd1);
    check("t6_tag", 64'(bus.ld_tag), 64'd20);
    check("t6_data", 64'(bus.ld_data), 64'hA000_0060);
    agu(1'b0, 1, 17'h61);
    for (int c = 0; c < 3; c++) begin
      check("t6_hold_valid", 64'(bus.ld_valid), 64'd1);
      check("t6_hold_tag", 64'(bus.ld_tag), 64'd20);
      check("t6_hold_data", 64'(bus.ld_data), 64'hA000_0060);
      tick();
    end
    reset = 1'b1;
    #1;
    check("t6_reset_drop", 64'(bus.ld_valid), 64'd0);
    tick();
    reset = 1'b0;
    bus.ld_ready = 1'b1;
    tick();
    tick();
    check("t6_queue_flushed", 64'(bus.ld_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
